// File: rtl/nbody_pkg.sv
// Shared types and constants for the three-body frame integrator.
// FSM encoding, body indices, reset coordinates and force levels live here.
package nbody_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAIR_AB,
    S_PAIR_AC,
    S_PAIR_BC,
    S_VEL,
    S_POS
  } state_t;

  // Accelerator and velocity widths (signed)
  localparam int ACC_W = 4;
  localparam int VEL_W = 5;

  localparam logic [1:0] BODY_A = 2'd0;
  localparam logic [1:0] BODY_B = 2'd1;
  localparam logic [1:0] BODY_C = 2'd2;

  localparam int RST_AX = 300;
  localparam int RST_AY = 150;
  localparam int RST_BX = 420;
  localparam int RST_BY = 300;
  localparam int RST_CX = 200;
  localparam int RST_CY = 20;

  localparam logic signed [ACC_W-1:0] FORCE_NONE = ACC_W'(0);
  localparam logic signed [ACC_W-1:0] FORCE_FAR  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] FORCE_NEAR = ACC_W'(2);

  // Axis k is body (k/2), x when k is even and y when k is odd.
  function automatic int reset_coord(input int k);
    case (k)
      0:       return RST_AX;
      1:       return RST_AY;
      2:       return RST_BX;
      3:       return RST_BY;
      4:       return RST_CX;
      default: return RST_CY;
    endcase
  endfunction

endpackage

// File: rtl/nbody_frame_integrator_pair_force.sv
// Combinational pairwise attraction: signed per-axis force that body i
// receives from body j (body j receives the negation).
module nbody_pair_force
  import nbody_pkg::*;
#(
  parameter int W      = 10,
  parameter int NEAR_D = 40,
  parameter int FAR_D  = 300
) (
  input  logic [W-1:0]            i_xi,
  input  logic [W-1:0]            i_yi,
  input  logic [W-1:0]            i_xj,
  input  logic [W-1:0]            i_yj,
  output logic signed [ACC_W-1:0] o_fx,
  output logic signed [ACC_W-1:0] o_fy
);

  localparam int DW = W + 1;
  localparam logic [DW-1:0] L_NEAR = DW'(NEAR_D);
  localparam logic [DW-1:0] L_FAR  = DW'(FAR_D);

  logic signed [DW-1:0]    w_dx;
  logic signed [DW-1:0]    w_dy;
  logic [DW-1:0]           w_adx;
  logic [DW-1:0]           w_ady;
  logic [DW-1:0]           w_d;
  logic signed [ACC_W-1:0] w_f;

  assign w_dx  = $signed({1'b0, i_xj}) - $signed({1'b0, i_xi});
  assign w_dy  = $signed({1'b0, i_yj}) - $signed({1'b0, i_yi});
  assign w_adx = w_dx[DW-1] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady = w_dy[DW-1] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_d   = w_adx + w_ady;

  // Coincident bodies exert no force, so the sign never has to be invented.
  always_comb begin
    w_f = FORCE_NONE;
    if (w_d == '0) begin
      w_f = FORCE_NONE;
    end else if (w_d < L_NEAR) begin
      w_f = FORCE_NEAR;
    end else if (w_d < L_FAR) begin
      w_f = FORCE_FAR;
    end
  end

  assign o_fx = (w_dx == '0) ? FORCE_NONE : (w_dx[DW-1] ? -w_f : w_f);
  assign o_fy = (w_dy == '0) ? FORCE_NONE : (w_dy[DW-1] ? -w_f : w_f);

endmodule

// File: rtl/nbody_frame_integrator.sv
// Per-frame three-body integrator: serial pair forces, velocity, position.
// Define BODY_BOUNCE_EN for reflecting screen edges; default build wraps.
module nbody_frame_integrator
  import nbody_pkg::*;
#(
  parameter int W        = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int NEAR_D   = 40,
  parameter int FAR_D    = 300,
  parameter int VMAX     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         load_en,
  input  logic [1:0]   load_sel,
  input  logic [W-1:0] load_x,
  input  logic [W-1:0] load_y,
  output logic [W-1:0] pos_ax,
  output logic [W-1:0] pos_ay,
  output logic [W-1:0] pos_bx,
  output logic [W-1:0] pos_by,
  output logic [W-1:0] pos_cx,
  output logic [W-1:0] pos_cy,
  output logic         busy,
  output logic         update_done,
  output logic         overrun
);

  localparam int PW = W + 2;
  localparam int SW = VEL_W + 1;
  localparam logic signed [SW-1:0]    L_VMAX_W = SW'(VMAX);
  localparam logic signed [VEL_W-1:0] L_VPOS   = VEL_W'(VMAX);
  localparam logic signed [VEL_W-1:0] L_VNEG   = -L_VPOS;

  state_t r_state;
  state_t w_state_next;
  logic   w_start;
  logic   w_load;
  logic   r_done;
  logic   r_overrun;

  logic [1:0]              w_idx_i;
  logic [1:0]              w_idx_j;
  logic [W-1:0]            w_xi;
  logic [W-1:0]            w_yi;
  logic [W-1:0]            w_xj;
  logic [W-1:0]            w_yj;
  logic signed [ACC_W-1:0] w_fx;
  logic signed [ACC_W-1:0] w_fy;
  logic [W-1:0]            w_load_x_mod;
  logic [W-1:0]            w_load_y_mod;
  logic [W-1:0]            w_p [6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A load in IDLE takes priority and swallows a coincident tick.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_load = 1'b1;
        end else if (frame_tick) begin
          w_start      = 1'b1;
          w_state_next = S_PAIR_AB;
        end
      end
      S_PAIR_AB: w_state_next = S_PAIR_AC;
      S_PAIR_AC: w_state_next = S_PAIR_BC;
      S_PAIR_BC: w_state_next = S_VEL;
      S_VEL:     w_state_next = S_POS;
      S_POS:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= (r_state == S_POS);
      r_overrun <= r_overrun | (busy & frame_tick);
    end
  end

  assign update_done = r_done;
  assign overrun     = r_overrun;

  // Time-multiplex the single force unit across the three pair states.
  always_comb begin
    w_idx_i = BODY_A;
    w_idx_j = BODY_B;
    w_xi    = w_p[0];
    w_yi    = w_p[1];
    w_xj    = w_p[2];
    w_yj    = w_p[3];
    case (r_state)
      S_PAIR_AC: begin
        w_idx_j = BODY_C;
        w_xj    = w_p[4];
        w_yj    = w_p[5];
      end
      S_PAIR_BC: begin
        w_idx_i = BODY_B;
        w_idx_j = BODY_C;
        w_xi    = w_p[2];
        w_yi    = w_p[3];
        w_xj    = w_p[4];
        w_yj    = w_p[5];
      end
      default: ;
    endcase
  end

  nbody_pair_force #(
    .W      (W),
    .NEAR_D (NEAR_D),
    .FAR_D  (FAR_D)
  ) u_pair_force (
    .i_xi (w_xi),
    .i_yi (w_yi),
    .i_xj (w_xj),
    .i_yj (w_yj),
    .o_fx (w_fx),
    .o_fy (w_fy)
  );

  assign w_load_x_mod = W'(load_x % H_ACTIVE);
  assign w_load_y_mod = W'(load_y % V_ACTIVE);

  // One slice per body axis: accelerator, velocity and position registers.
  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_axis
    localparam bit         L_IS_X = ((gi % 2) == 0);
    localparam logic [1:0] L_BODY = 2'(gi / 2);
    localparam logic signed [PW-1:0] L_LIM = L_IS_X ? PW'(H_ACTIVE) : PW'(V_ACTIVE);

    logic [W-1:0]            r_p;
    logic signed [VEL_W-1:0] r_v;
    logic signed [ACC_W-1:0] r_a;
    logic signed [ACC_W-1:0] w_f;
    logic signed [SW-1:0]    w_vsum;
    logic signed [VEL_W-1:0] w_vsat;
    logic signed [VEL_W-1:0] w_vpos;
    logic signed [PW-1:0]    w_psum;
    logic [W-1:0]            w_pnew;
    logic [W-1:0]            w_load_val;

    assign w_f        = L_IS_X ? w_fx : w_fy;
    assign w_load_val = L_IS_X ? w_load_x_mod : w_load_y_mod;

    assign w_vsum = {r_v[VEL_W-1], r_v} + {{(SW-ACC_W){r_a[ACC_W-1]}}, r_a};
    assign w_vsat = (w_vsum > L_VMAX_W)  ? L_VPOS :
                    (w_vsum < -L_VMAX_W) ? L_VNEG : w_vsum[VEL_W-1:0];

    // Position step uses the velocity already committed in VEL.
    assign w_psum = {2'b00, r_p} + {{(PW-VEL_W){r_v[VEL_W-1]}}, r_v};

    always_comb begin
      w_pnew = w_psum[W-1:0];
      w_vpos = r_v;
`ifdef BODY_BOUNCE_EN
      if (w_psum[PW-1]) begin
        w_pnew = '0;
        w_vpos = -r_v;
      end else if (w_psum >= L_LIM) begin
        w_pnew = W'(L_LIM - 1);
        w_vpos = -r_v;
      end
`else
      if (w_psum[PW-1]) begin
        w_pnew = W'(w_psum + L_LIM);
      end else if (w_psum >= L_LIM) begin
        w_pnew = W'(w_psum - L_LIM);
      end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_p <= W'(reset_coord(gi));
        r_v <= '0;
        r_a <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_load && (load_sel == L_BODY)) begin
              r_p <= w_load_val;
              r_v <= '0;
            end
            if (w_start) begin
              r_a <= '0;
            end
          end
          S_PAIR_AB, S_PAIR_AC, S_PAIR_BC: begin
            if (w_idx_i == L_BODY) begin
              r_a <= r_a + w_f;
            end else if (w_idx_j == L_BODY) begin
              r_a <= r_a - w_f;
            end
          end
          S_VEL: r_v <= w_vsat;
          S_POS: begin
            r_p <= w_pnew;
            r_v <= w_vpos;
          end
          default: ;
        endcase
      end
    end

    assign w_p[gi] = r_p;
  end

  assign pos_ax = w_p[0];
  assign pos_ay = w_p[1];
  assign pos_bx = w_p[2];
  assign pos_by = w_p[3];
  assign pos_cx = w_p[4];
  assign pos_cy = w_p[5];

endmodule
